// File: rtl/polyphase_coeff_bank.sv
// Double-buffered filter coefficient store: cfg port fills the shadow bank, a commit swaps banks on a frame boundary, then the new active bank is copied back into the shadow.
// Reads are 1-cycle and never stall; cfg writes/commits while busy are dropped (sticky cfg_err). Macro POLYPHASE_COEFF_SWAP_CNT_EN builds the swap counter.
module polyphase_coeff_bank #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_wdata,
  input  logic [DATA_W/8-1:0]   cfg_wen,
  output logic [DATA_W-1:0]     cfg_rdata,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  frame_boundary,
  input  logic                  coef_rd_en,
  input  logic [ADDR_W-1:0]     coef_rd_addr,
  output logic [DATA_W-1:0]     coef_rd_data,
  output logic                  active_bank,
  output logic [7:0]            swap_count
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] IDX_END = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t              state_q, state_d;
  logic                active_q;
  logic [ADDR_W:0]     idx_q;
  logic [DATA_W-1:0]   copy_dat_q;
  logic                err_q;

  logic [DATA_W-1:0]   bank0 [DEPTH];
  logic [DATA_W-1:0]   bank1 [DEPTH];

  logic                busy;
  logic                err_set;
  logic                err_clr;
  logic                swap;
  logic                copy_rd;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NB-1:0]       wr_be;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    swap    = 1'b0;
    copy_rd = 1'b0;
    wr_en   = 1'b0;
    wr_addr = cfg_addr;
    wr_data = cfg_wdata;
    wr_be   = cfg_wen;
    case (state_q)
      IDLE: begin
        wr_en = |cfg_wen;
        // A boundary coinciding with the commit is deliberately not used.
        if (cfg_commit) begin
          state_d = PENDING;
          err_clr = 1'b1;
        end
      end
      PENDING: begin
        busy    = 1'b1;
        err_set = cfg_commit | (|cfg_wen);
        if (frame_boundary) begin
          swap    = 1'b1;
          state_d = COPY;
        end
      end
      COPY: begin
        busy    = 1'b1;
        err_set = cfg_commit | (|cfg_wen);
        copy_rd = (idx_q < IDX_END);
        // Write lags the read by one cycle: shadow[idx-1] gets the word read last cycle.
        if (idx_q != '0) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_W'(idx_q - 1'b1);
          wr_data = copy_dat_q;
          wr_be   = '1;
        end
        if (idx_q == IDX_END) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      idx_q        <= '0;
      copy_dat_q   <= '0;
      err_q        <= 1'b0;
      cfg_rdata    <= '0;
      coef_rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (swap) begin
        active_q <= ~active_q;
        idx_q    <= '0;
      end else if (copy_rd) begin
        idx_q <= idx_q + 1'b1;
      end
      if (copy_rd)
        copy_dat_q <= active_q ? bank1[idx_q[ADDR_W-1:0]] : bank0[idx_q[ADDR_W-1:0]];
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      cfg_rdata <= active_q ? bank0[cfg_addr] : bank1[cfg_addr];
      if (coef_rd_en)
        coef_rd_data <= active_q ? bank1[coef_rd_addr] : bank0[coef_rd_addr];
    end
  end

  // Only the shadow bank is ever written.
  always_ff @(posedge axi_aclk) begin
    if (wr_en && active_q) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) bank0[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (wr_en && !active_q) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) bank1[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

`ifdef POLYPHASE_COEFF_SWAP_CNT_EN
  logic [7:0] swap_cnt_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) swap_cnt_q <= 8'd0;
    else if (swap)    swap_cnt_q <= swap_cnt_q + 8'd1;
  end

  assign swap_count = swap_cnt_q;
`else
  assign swap_count = 8'd0;
`endif

  assign cfg_busy    = busy;
  assign cfg_err     = err_q;
  assign active_bank = active_q;

endmodule

// File: tb/tb_polyphase_coeff_bank.sv
// Directed bench for polyphase_coeff_bank: bank swap timing, byte writes, busy drops and counter wrap.
module tb_polyphase_coeff_bank;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [3:0]        cfg_wen;
  logic [DATA_W-1:0] cfg_rdata;
  logic              cfg_commit;
  logic              cfg_busy;
  logic              cfg_err;
  logic              frame_boundary;
  logic              coef_rd_en;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic [DATA_W-1:0] coef_rd_data;
  logic              active_bank;
  logic [7:0]        swap_count;

  polyphase_coeff_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .axi_aclk       (axi_aclk),
    .axi_aresetn    (axi_aresetn),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_wen        (cfg_wen),
    .cfg_rdata      (cfg_rdata),
    .cfg_commit     (cfg_commit),
    .cfg_busy       (cfg_busy),
    .cfg_err        (cfg_err),
    .frame_boundary (frame_boundary),
    .coef_rd_en     (coef_rd_en),
    .coef_rd_addr   (coef_rd_addr),
    .coef_rd_data   (coef_rd_data),
    .active_bank    (active_bank),
    .swap_count     (swap_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  int          checks   = 0;
  int          failures = 0;
  int          swaps    = 0;
  logic        exp_bank = 1'b0;
  logic [31:0] sh [DEPTH];
  logic [31:0] ac [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  function automatic logic [7:0] exp_cnt();
`ifdef POLYPHASE_COEFF_SWAP_CNT_EN
    return swaps[7:0];
`else
    return 8'd0;
`endif
  endfunction

  task automatic cfg_write(input int a, input logic [31:0] d, input logic [3:0] be);
    cfg_addr  = ADDR_W'(a);
    cfg_wdata = d;
    cfg_wen   = be;
    step();
    cfg_wen   = 4'h0;
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) sh[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_swap();
    for (int i = 0; i < DEPTH; i++) ac[i] = sh[i];
    swaps++;
    exp_bank = ~exp_bank;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 2000 && cfg_busy; n++) step();
    check(tag, {31'd0, cfg_busy}, 32'd0);
  endtask

  task automatic do_swap(input int gap, input string tag);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    repeat (gap) step();
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    model_swap();
    wait_idle(tag);
  endtask

  task automatic verify_all(input string tag);
    int bad = 0;
    coef_rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cfg_addr     = ADDR_W'(i);
      coef_rd_addr = ADDR_W'(i);
      step();
      if (cfg_rdata !== sh[i] || coef_rd_data !== ac[i]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    axi_aresetn    = 1'b0;
    cfg_addr       = '0;
    cfg_wdata      = '0;
    cfg_wen        = 4'h0;
    cfg_commit     = 1'b0;
    frame_boundary = 1'b0;
    coef_rd_en     = 1'b0;
    coef_rd_addr   = '0;
    repeat (3) step();
    check("rst_active_bank", {31'd0, active_bank}, 32'd0);
    check("rst_busy", {31'd0, cfg_busy}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    check("rst_swap_count", {24'd0, swap_count}, 32'd0);
    check("rst_cfg_rdata", cfg_rdata, 32'd0);
    check("rst_coef_rd_data", coef_rd_data, 32'd0);
    axi_aresetn = 1'b1;
    step();

    // Fill both banks with a known pattern via two swaps.
    for (int i = 0; i < DEPTH; i++) begin
      cfg_write(i, pat(i), 4'hF);
      model_write(i, pat(i), 4'hF);
    end
    do_swap(2, "init_swap1_idle");
    do_swap(2, "init_swap2_idle");
    check("init_active_bank", {31'd0, active_bank}, {31'd0, exp_bank});
    verify_all("init_banks_consistent");

    // Full-word write; read-during-write returns old data; active bank untouched.
    coef_rd_en   = 1'b1;
    coef_rd_addr = 9'd5;
    cfg_write(5, 32'hDEADBEEF, 4'hF);
    check("rdw_returns_old", cfg_rdata, sh[5]);
    model_write(5, 32'hDEADBEEF, 4'hF);
    step();
    check("cfg_rd_full_write", cfg_rdata, 32'hDEADBEEF);
    check("coef_active_unchanged", coef_rd_data, pat(5));
    coef_rd_en   = 1'b0;
    coef_rd_addr = 9'd6;
    step();
    check("coef_holds_without_en", coef_rd_data, pat(5));

    // Byte-0-only write.
    cfg_write(5, 32'h11223344, 4'hF);
    model_write(5, 32'h11223344, 4'hF);
    cfg_write(5, 32'h0000BEEF, 4'h1);
    model_write(5, 32'h0000BEEF, 4'h1);
    step();
    check("cfg_rd_byte0_write", cfg_rdata, 32'h112233EF);

    // Commit, boundary 10 cycles later, busy length, new bank visible next cycle.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    repeat (9) step();
    check("pending_busy", {31'd0, cfg_busy}, 32'd1);
    check("pending_no_swap", {31'd0, active_bank}, 32'd0);
    frame_boundary = 1'b1;
    coef_rd_en     = 1'b1;
    coef_rd_addr   = 9'd5;
    n = 0;
    if (cfg_busy) n++;
    step();
    frame_boundary = 1'b0;
    check("coef_boundary_cycle_old_bank", coef_rd_data, pat(5));
    model_swap();
    check("swap_active_bank", {31'd0, active_bank}, 32'd1);
    while (cfg_busy && n < 2000) begin
      n++;
      step();
      if (n == 2) check("coef_new_bank", coef_rd_data, 32'h112233EF);
    end
    check("busy_cycles", 32'(n), 32'(DEPTH + 2));
    check("swap_count_1", {24'd0, swap_count}, {24'd0, exp_cnt()});
    verify_all("copy_consistent");

    // Write and commit while in COPY are dropped and set cfg_err.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("accepted_commit_err", {31'd0, cfg_err}, 32'd0);
    repeat (2) step();
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    model_swap();
    repeat (20) step();
    cfg_write(2, 32'hBAD0BAD0, 4'hF);
    check("copy_write_err", {31'd0, cfg_err}, 32'd1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("copy_commit_busy", {31'd0, cfg_busy}, 32'd1);
    wait_idle("copy_drop_idle");
    check("err_sticky", {31'd0, cfg_err}, 32'd1);
    check("active_after_drop", {31'd0, active_bank}, {31'd0, exp_bank});
    verify_all("dropped_write_absent");

    // Commit and boundary in the same IDLE cycle: no swap yet.
    cfg_commit     = 1'b1;
    frame_boundary = 1'b1;
    step();
    cfg_commit     = 1'b0;
    frame_boundary = 1'b0;
    check("same_cycle_no_swap", {31'd0, active_bank}, {31'd0, exp_bank});
    check("same_cycle_pending", {31'd0, cfg_busy}, 32'd1);
    check("same_cycle_err_clr", {31'd0, cfg_err}, 32'd0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    check("pending_commit_err", {31'd0, cfg_err}, 32'd1);
    repeat (3) step();
    check("still_no_swap", {31'd0, active_bank}, {31'd0, exp_bank});
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    model_swap();
    check("next_boundary_swap", {31'd0, active_bank}, {31'd0, exp_bank});
    wait_idle("same_cycle_idle");
    do_swap(1, "clear_err_idle");
    check("commit_clears_err", {31'd0, cfg_err}, 32'd0);
    check("swap_count_mid", {24'd0, swap_count}, {24'd0, exp_cnt()});

`ifdef POLYPHASE_COEFF_SWAP_CNT_EN
    while (swaps < 257) do_swap(1, "wrap_idle");
    check("swap_count_wrap", {24'd0, swap_count}, 32'd1);
`endif

    // Reset in the middle of COPY.
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    frame_boundary = 1'b1;
    step();
    frame_boundary = 1'b0;
    model_swap();
    repeat (30) step();
    check("mid_copy_busy", {31'd0, cfg_busy}, 32'd1);
    check("mid_copy_bank", {31'd0, active_bank}, {31'd0, exp_bank});
    axi_aresetn = 1'b0;
    #2;
    check("rst_copy_active_bank", {31'd0, active_bank}, 32'd0);
    check("rst_copy_busy", {31'd0, cfg_busy}, 32'd0);
    check("rst_copy_swap_count", {24'd0, swap_count}, 32'd0);
    step();
    axi_aresetn = 1'b1;
    repeat (2) step();
    check("post_rst_idle", {31'd0, cfg_busy}, 32'd0);
    check("post_rst_bank", {31'd0, active_bank}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
